// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pipe_pkg
// Brief    : Shared constants and types for the RV pipeline front end.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

  localparam int          c_ilen     = 32;
  localparam logic [31:0] c_nop      = 32'h0000_0013;
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  typedef struct packed {
    logic [c_ilen-1:0] pc;
    logic [c_ilen-1:0] instr;
  } fetch_entry_t;

  function automatic logic [c_ilen-1:0] pc_plus4(input logic [c_ilen-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of {pc, instr} entries with flush and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge CLK) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch stage feeding the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter int          DEPTH    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_REQ,
  output logic [c_ilen-1:0] IMEM_ADDR,
  input  logic              IMEM_READY,
  input  logic              IMEM_RVALID,
  input  logic [c_ilen-1:0] IMEM_RDATA,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [c_ilen-1:0] REDIRECT_PC,
  output logic              VALID_IF,
  output logic [c_ilen-1:0] PC_IF,
  output logic [c_ilen-1:0] PC4_IF,
  output logic [c_ilen-1:0] IDATA_IF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [c_ilen-1:0] r_fetch_pc;
  logic [c_ilen-1:0] r_resp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard;

  logic [CW-1:0]     w_count;
  logic [CW:0]       w_credit;
  logic              w_req;
  logic              w_accept;
  logic              w_rsp;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_out_next;
  logic [c_ilen-1:0] w_redir_pc;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  assign w_credit   = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_req      = w_credit < (CW+1)'(DEPTH);
  assign w_accept   = w_req && IMEM_READY;
  // A response with nothing outstanding is a leftover from before reset.
  assign w_rsp      = IMEM_RVALID && (r_outstanding != '0);
  assign w_valid    = (w_count != '0);
  assign w_pop      = w_valid && !STALL && !REDIRECT;
  assign w_push     = w_rsp && (r_discard == '0) && !REDIRECT;
  assign w_out_next = r_outstanding + CW'(w_accept) - CW'(w_rsp);
  assign w_redir_pc = REDIRECT_PC & 32'hFFFF_FFFC;

  assign w_push_entry = '{pc: r_resp_pc, instr: IMEM_RDATA};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * c_ilen)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (REDIRECT),
    .head_data (w_head),
    .count     (w_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (REDIRECT) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_discard  <= w_out_next;
      end else begin
        if (w_accept) r_fetch_pc <= pc_plus4(r_fetch_pc);
        if (w_rsp) begin
          if (r_discard != '0) r_discard <= r_discard - CW'(1);
          else                 r_resp_pc <= pc_plus4(r_resp_pc);
        end
      end
    end
  end

  assign IMEM_REQ  = w_req;
  assign IMEM_ADDR = r_fetch_pc;
  assign VALID_IF  = w_valid;
  assign PC_IF     = w_valid ? w_head.pc : r_resp_pc;
  assign PC4_IF    = pc_plus4(PC_IF);
  assign IDATA_IF  = w_valid ? w_head.instr : c_nop;

endmodule
`default_nettype wire
